// File: rtl/uart_instr_loader.sv
// uart_instr_loader: boot-time program loader. Parses a 32-bit little-endian
// word-count header from the UART byte stream, assembles little-endian 32-bit
// instruction words, issues one imem write per word, then raises start.
module uart_instr_loader #(
  parameter int unsigned MAX_WORDS      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] write_byte_address,
  output logic [31:0] write_instr_data,
  output logic        write_instr_valid,
  output logic        start,
  output logic        load_error,
  output logic [31:0] words_loaded
);

  typedef enum logic [1:0] {
    S_LEN  = 2'd0,
    S_DATA = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  byte_cnt, byte_cnt_nxt;
  logic [23:0] byte_sr, byte_sr_nxt;
  logic [31:0] len, len_nxt;
  logic [31:0] word_idx, word_idx_nxt;
  logic [31:0] idle_cnt, idle_cnt_nxt;
  logic [31:0] addr_nxt, data_nxt, words_nxt;
  logic        valid_nxt, start_nxt, err_nxt;
  logic [31:0] assembled;
  logic [31:0] word_idx_inc;
  logic        in_frame;

  // The three earlier bytes sit in byte_sr, first byte lowest.
  assign assembled    = {rx_data, byte_sr};
  assign word_idx_inc = word_idx + 32'd1;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_LEN;
    else     state <= state_nxt;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt           <= '0;
      byte_sr            <= '0;
      len                <= '0;
      word_idx           <= '0;
      idle_cnt           <= '0;
      write_byte_address <= '0;
      write_instr_data   <= '0;
      write_instr_valid  <= 1'b0;
      start              <= 1'b0;
      load_error         <= 1'b0;
      words_loaded       <= '0;
    end else begin
      byte_cnt           <= byte_cnt_nxt;
      byte_sr            <= byte_sr_nxt;
      len                <= len_nxt;
      word_idx           <= word_idx_nxt;
      idle_cnt           <= idle_cnt_nxt;
      write_byte_address <= addr_nxt;
      write_instr_data   <= data_nxt;
      write_instr_valid  <= valid_nxt;
      start              <= start_nxt;
      load_error         <= err_nxt;
      words_loaded       <= words_nxt;
    end
  end

  // Next-state and next-output logic: byte capture, header check, word
  // write, and the idle timeout inside a partial frame.
  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    byte_sr_nxt  = byte_sr;
    len_nxt      = len;
    word_idx_nxt = word_idx;
    idle_cnt_nxt = idle_cnt;
    addr_nxt     = write_byte_address;
    data_nxt     = write_instr_data;
    valid_nxt    = 1'b0;
    start_nxt    = start;
    err_nxt      = load_error;
    words_nxt    = words_loaded;
    in_frame     = (state == S_DATA) || ((state == S_LEN) && (byte_cnt != 2'd0));

    case (state)
      S_LEN, S_DATA: begin
        if (rx_valid) begin
          idle_cnt_nxt = '0;
          byte_sr_nxt  = {rx_data, byte_sr[23:8]};
          byte_cnt_nxt = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            if (state == S_LEN) begin
              if ((assembled == 32'd0) || (assembled > 32'(MAX_WORDS))) begin
                err_nxt = 1'b1;
              end else begin
                err_nxt      = 1'b0;
                words_nxt    = '0;
                len_nxt      = assembled;
                word_idx_nxt = '0;
                state_nxt    = S_DATA;
              end
            end else begin
              valid_nxt    = 1'b1;
              data_nxt     = assembled;
              addr_nxt     = word_idx << 2;
              words_nxt    = word_idx_inc;
              word_idx_nxt = word_idx_inc;
              if (word_idx_inc == len) state_nxt = S_RUN;
            end
          end
        end else if (in_frame) begin
          if (idle_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
            err_nxt      = 1'b1;
            state_nxt    = S_LEN;
            byte_cnt_nxt = '0;
            idle_cnt_nxt = '0;
          end else begin
            idle_cnt_nxt = idle_cnt + 32'd1;
          end
        end
      end
      S_RUN: begin
        // Entered on the final strobe edge, so start rises one edge later.
        start_nxt = 1'b1;
      end
      default: state_nxt = S_LEN;
    endcase
  end

endmodule
